// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants and state encoding for the RV32M multiply/divide unit
package mdu_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide unit with register-file write-back strobe
// Operands are reduced to magnitudes at start; signs are reapplied in FIX.
module mul_div_unit
  import mdu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  input  logic [4:0]       rd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rw,
  output logic             regwr
);

  state_t               r_state;
  state_t               w_next;
  logic [2:0]           r_op;
  logic [4:0]           r_rd;
  logic [5:0]           r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic                 r_neg_main;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_result;
  logic [4:0]           r_rw;

  logic                 w_a_signed;
  logic                 w_b_signed;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_is_div;
  logic                 w_div_zero;
  logic                 w_overflow;
  logic                 w_fast;
  logic [WIDTH-1:0]     w_fast_result;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_div_next;

  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_result;

  assign w_a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) ||
                      (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_a_neg    = w_a_signed & busA[WIDTH-1];
  assign w_b_neg    = w_b_signed & busB[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~busA + 32'd1) : busA;
  assign w_b_mag    = w_b_neg ? (~busB + 32'd1) : busB;

  assign w_is_div   = funct3[2];
  assign w_div_zero = w_is_div && (busB == 32'd0);
  assign w_overflow = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (busA == 32'h8000_0000) && (busB == 32'hFFFF_FFFF);
  assign w_fast     = w_div_zero || w_overflow;

  // funct3[1] distinguishes REM/REMU from DIV/DIVU among the divide codes
  always_comb begin
    w_fast_result = 32'd0;
    if (w_div_zero) begin
      w_fast_result = funct3[1] ? busA : 32'hFFFF_FFFF;
    end else if (w_overflow) begin
      w_fast_result = funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring step: upper half is the partial remainder, lower half shifts dividend out / quotient in
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = w_shift >= {1'b0, r_opb};
  assign w_diff     = w_shift[WIDTH-1:0] - r_opb;
  assign w_div_next = {(w_ge ? w_diff : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_prod = r_neg_main ? (~r_acc + 64'd1) : r_acc;
  assign w_quo  = r_neg_main ? (~r_acc[WIDTH-1:0] + 32'd1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 32'd1) : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_result = 32'd0;
    case (r_op)
      F3_MUL:                       w_fix_result = w_prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:              w_fix_result = w_quo;
      default:                      w_fix_result = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_fast ? ST_DONE : ST_CALC;
      ST_CALC: if (r_count == 6'(ITERATIONS - 1)) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 3'd0;
      r_rd       <= 5'd0;
      r_count    <= 6'd0;
      r_acc      <= 64'd0;
      r_opb      <= 32'd0;
      r_neg_main <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= 32'd0;
      r_rw       <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op       <= funct3;
            r_rd       <= rd;
            r_count    <= 6'd0;
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_acc      <= {32'd0, (w_is_div ? w_a_mag : w_b_mag)};
            r_opb      <= w_is_div ? w_b_mag : w_a_mag;
            if (w_fast) begin
              r_result <= w_fast_result;
              r_rw     <= rd;
            end
          end
        end
        ST_CALC: begin
          r_acc   <= r_op[2] ? w_div_next : w_mul_next;
          r_count <= r_count + 6'd1;
        end
        ST_FIX: begin
          r_result <= w_fix_result;
          r_rw     <= r_rd;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign regwr  = done && (r_rw != 5'd0);
  assign result = r_result;
  assign rw     = r_rw;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed and randomized checks of mul_div_unit against an arithmetic model
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] busA;
  logic [31:0] busB;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rw;
  logic        regwr;

  int n_vec = 0;
  int n_err = 0;

  mul_div_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .busA   (busA),
    .busB   (busB),
    .rd     (rd),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rw     (rw),
    .regwr  (regwr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    int          ia;
    int          ib;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // poke > 0 pulses start with junk inputs on that cycle of the run, which must be ignored
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp, input int poke);
    int n;
    bit seen;
    bit fast;
    fast = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    @(negedge clk);
    funct3 = f; busA = a; busB = b; rd = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = 3'($urandom); busA = $urandom; busB = $urandom; rd = 5'($urandom);
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      seen = done;
      if (!seen && poke != 0 && n == poke) begin
        start = 1'b1; funct3 = 3'($urandom); busA = $urandom; busB = $urandom; rd = 5'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", 32'(n), fast ? 32'd1 : 32'd34);
    check("result", result, exp);
    check("rw", 32'(rw), 32'(d));
    check("regwr", 32'(regwr), (d != 0) ? 32'd1 : 32'd0);
    check("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("result_hold", result, exp);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    bit          seen;
    rst = 1'b1; start = 1'b0; funct3 = 3'd0; busA = 32'd0; busB = 32'd0; rd = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_regwr", 32'(regwr), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    rst = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0);
    run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 0);
    run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 0);
    run_op(3'd5, 32'h1234, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
    run_op(3'd6, 32'h1234, 32'd0, 5'd10, 32'h1234, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 5);

    @(negedge clk);
    funct3 = 3'd4; busA = 32'd1000; busB = 32'd3; rd = 5'd13; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_regwr", 32'(regwr), 32'd0);
    check("midrst_result", result, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || regwr) seen = 1'b1;
    end
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || regwr) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 32'd0);
    run_op(3'd0, 32'd2, 32'd3, 5'd14, 32'd6, 0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      case ($urandom_range(0, 7))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      d = 5'($urandom);
      run_op(f, a, b, d, model(f, a, b), ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 30)) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
